// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache replacement-state sequencer.
//   DEF_LOG2_WAYS / DEF_INDEX_BITS : default pointer and set-index widths
//   lru_state_e                    : sequencer states (INIT sweep, RUN)
//   lru_next()                     : round-robin successor of a way
package dcache_pkg;

  localparam int unsigned DEF_LOG2_WAYS  = 3;
  localparam int unsigned DEF_INDEX_BITS = 8;

  typedef enum logic {
    INIT,
    RUN
  } lru_state_e;

  // (way + 1) mod 2**log2_ways; callers truncate to their pointer width.
  function automatic int unsigned lru_next(input int unsigned way,
                                           input int unsigned log2_ways);
    return (way + 32'd1) % (32'd1 << log2_ways);
  endfunction

endpackage

// File: rtl/dcache_lru_ctrl_if.sv
// Cache-pipeline side of the replacement-state sequencer.
//   lk_valid/lk_ready/lk_index : victim lookup request handshake
//   rsp_valid/rsp_victim       : victim response, one cycle after acceptance
//   upd_valid/upd_index/upd_way: fill notification (no backpressure)
// master = cache control FSM, slave = dcache_lru_ctrl.
interface dcache_lru_ctrl_if #(
  parameter int unsigned LOG2_WAYS  = 3,
  parameter int unsigned INDEX_BITS = 8
) ();

  logic                  lk_valid;
  logic                  lk_ready;
  logic [INDEX_BITS-1:0] lk_index;
  logic                  rsp_valid;
  logic [LOG2_WAYS-1:0]  rsp_victim;
  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic [LOG2_WAYS-1:0]  upd_way;

  modport master (
    output lk_valid, lk_index, upd_valid, upd_index, upd_way,
    input  lk_ready, rsp_valid, rsp_victim
  );

  modport slave (
    input  lk_valid, lk_index, upd_valid, upd_index, upd_way,
    output lk_ready, rsp_valid, rsp_victim
  );

endinterface

// File: rtl/dcache_lru_ctrl.sv
// Replacement-state RAM sequencer: one round-robin victim pointer per set.
// Zero-fills the external RAM after reset or flush, serves victim lookups
// with 1-cycle latency and writes pointer+1 on every completed fill.
//   clock, aclr_n      : clock (rising edge), async active-low reset
//   flush, busy        : re-run init sweep / sweep in progress
//   pipe               : lookup / response / update bundle (slave side)
//   ram_*              : read and write ports of the replacement RAM
//   ram_q              : RAM read data, valid the cycle after ram_rden
module dcache_lru_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LOG2_WAYS  = DEF_LOG2_WAYS,
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  flush,
  output logic                  busy,
  dcache_lru_ctrl_if.slave      pipe,
  output logic                  ram_rden,
  output logic [INDEX_BITS-1:0] ram_rdaddress,
  output logic                  ram_wren,
  output logic [INDEX_BITS-1:0] ram_wraddress,
  output logic [LOG2_WAYS-1:0]  ram_data,
  input  logic [LOG2_WAYS-1:0]  ram_q
);

  lru_state_e            state_q, state_d;
  logic [INDEX_BITS-1:0] cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [LOG2_WAYS-1:0]  victim_q, victim_d;
  logic                  lk_fire;

  // State register
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      victim_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      victim_q    <= victim_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: ;
      default: ;
    endcase
    // Flush restarts the sweep from either state.
    if (flush) begin
      state_d = INIT;
      cnt_d   = '0;
    end
  end

  // Output logic. Outputs are forced idle while aclr_n is low so the RAM
  // sees no sweep write during reset, yet the first write still lands in
  // the first cycle after release.
  always_comb begin
    busy          = 1'b1;
    pipe.lk_ready = 1'b0;
    ram_rden      = 1'b0;
    ram_rdaddress = '0;
    ram_wren      = 1'b0;
    ram_wraddress = '0;
    ram_data      = '0;
    if (aclr_n) begin
      unique case (state_q)
        INIT: begin
          ram_wren      = 1'b1;
          ram_wraddress = cnt_q;
        end
        RUN: begin
          busy          = 1'b0;
          pipe.lk_ready = 1'b1;
          if (pipe.lk_valid) begin
            ram_rden      = 1'b1;
            ram_rdaddress = pipe.lk_index;
          end
          if (pipe.upd_valid) begin
            ram_wren      = 1'b1;
            ram_wraddress = pipe.upd_index;
            ram_data      = LOG2_WAYS'(lru_next(32'(pipe.upd_way), LOG2_WAYS));
          end
        end
        default: ;
      endcase
    end
  end

  assign lk_fire = pipe.lk_valid && pipe.lk_ready;

  // Response: ram_q is only valid in the pulse cycle, so it is passed
  // through then and captured for the hold value afterwards.
  always_comb begin
    rsp_valid_d = lk_fire;
    victim_d    = rsp_valid_q ? ram_q : victim_q;
  end

  assign pipe.rsp_valid  = rsp_valid_q;
  assign pipe.rsp_victim = rsp_valid_q ? ram_q : victim_q;

endmodule

// File: tb/tb_dcache_lru_ctrl.sv
module tb_dcache_lru_ctrl;

  localparam int LW       = 3;
  localparam int IB       = 8;
  localparam int WAYS     = 1 << LW;
  localparam int NUM_SETS = 1 << IB;

  logic          clock;
  logic          aclr_n;
  logic          flush;
  logic          busy;
  logic          ram_rden;
  logic [IB-1:0] ram_rdaddress;
  logic          ram_wren;
  logic [IB-1:0] ram_wraddress;
  logic [LW-1:0] ram_data;
  logic [LW-1:0] ram_q;

  dcache_lru_ctrl_if #(.LOG2_WAYS(LW), .INDEX_BITS(IB)) pipe_if ();

  dcache_lru_ctrl #(.LOG2_WAYS(LW), .INDEX_BITS(IB)) dut (
    .clock         (clock),
    .aclr_n        (aclr_n),
    .flush         (flush),
    .busy          (busy),
    .pipe          (pipe_if),
    .ram_rden      (ram_rden),
    .ram_rdaddress (ram_rdaddress),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_q         (ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Replacement RAM as the parent would provide it: registered read,
  // same-cycle write-to-read forwarding.
  logic [LW-1:0] mem [NUM_SETS];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    if (ram_rden)
      ram_q <= (ram_wren && ram_wraddress == ram_rdaddress) ? ram_data : mem[ram_rdaddress];
  end

  // Reference model: victim pointer per set, sweep position (-1 = running).
  int model_ptr [NUM_SETS];
  int sweep_pos;
  int last_victim;
  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_sweep();
    sweep_pos = 0;
    foreach (model_ptr[i]) model_ptr[i] = 0;
  endtask

  task automatic check_reset_values();
    chk("rst_busy", busy, 1);
    chk("rst_lk_ready", pipe_if.lk_ready, 0);
    chk("rst_rsp_valid", pipe_if.rsp_valid, 0);
    chk("rst_rsp_victim", pipe_if.rsp_victim, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_ram_rden", ram_rden, 0);
    chk("rst_ram_rdaddress", ram_rdaddress, 0);
    chk("rst_ram_wraddress", ram_wraddress, 0);
    chk("rst_ram_data", ram_data, 0);
  endtask

  // Asserts reset mid-cycle, checks outputs idle at once, releases after
  // one clock edge.
  task automatic do_reset();
    pipe_if.lk_valid  = 1'b0;
    pipe_if.upd_valid = 1'b0;
    flush             = 1'b0;
    aclr_n            = 1'b0;
    #1;
    check_reset_values();
    @(posedge clock);
    #1;
    check_reset_values();
    aclr_n = 1'b1;
    start_sweep();
    last_victim = 0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, advance the model, then check the response after the edge.
  task automatic tick(input bit lkv, input int lki, input bit updv,
                      input int updi, input int updw, input bit fl);
    bit run;
    bit acc;
    int exp_v;
    pipe_if.lk_valid  = lkv;
    pipe_if.lk_index  = IB'(lki);
    pipe_if.upd_valid = updv;
    pipe_if.upd_index = IB'(updi);
    pipe_if.upd_way   = LW'(updw);
    flush             = fl;
    #1;
    run = (sweep_pos < 0);
    chk("busy", busy, !run);
    chk("lk_ready", pipe_if.lk_ready, run);
    chk("ram_rden", ram_rden, run && lkv);
    if (run && lkv) chk("ram_rdaddress", ram_rdaddress, lki);
    chk("ram_wren", ram_wren, !run || updv);
    if (!run) begin
      chk("sweep_wraddress", ram_wraddress, sweep_pos);
      chk("sweep_data", ram_data, 0);
    end else if (updv) begin
      chk("upd_wraddress", ram_wraddress, updi);
      chk("upd_data", ram_data, (updw + 1) % WAYS);
    end
    acc   = run && lkv;
    exp_v = 0;
    if (run && updv) model_ptr[updi] = (updw + 1) % WAYS;
    if (acc) exp_v = model_ptr[lki];
    if (fl) start_sweep();
    else if (!run) begin
      sweep_pos++;
      if (sweep_pos == NUM_SETS) sweep_pos = -1;
    end
    @(posedge clock);
    #1;
    chk("rsp_valid", pipe_if.rsp_valid, acc);
    if (acc) last_victim = exp_v;
    chk("rsp_victim", pipe_if.rsp_victim, last_victim);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input int idx);
    tick(1, idx, 0, 0, 0, 0);
  endtask

  task automatic update(input int idx, input int way);
    tick(0, 0, 1, idx, way, 0);
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    aclr_n            = 1'b0;
    flush             = 1'b0;
    pipe_if.lk_valid  = 1'b0;
    pipe_if.lk_index  = '0;
    pipe_if.upd_valid = 1'b0;
    pipe_if.upd_index = '0;
    pipe_if.upd_way   = '0;
    #2;
    do_reset();

    // Power-up sweep, then RUN: lookups of fresh sets return 0.
    idle(NUM_SETS);
    lookup(0);
    lookup(200);

    // Update then lookup; way WAYS-1 wraps to 0.
    update(5, 2);
    lookup(5);
    update(5, 7);
    lookup(5);

    // Same-cycle update + lookup is forwarded; lookup one cycle ahead of
    // an update sees the prior value.
    tick(1, 9, 1, 9, 4, 0);
    tick(1, 9, 0, 0, 0, 0);
    tick(0, 0, 1, 9, 6, 0);
    lookup(9);

    // Back-to-back lookups after distinct updates.
    update(1, 0);
    update(2, 1);
    update(3, 2);
    lookup(1);
    lookup(2);
    lookup(3);

    // Random traffic over a small set range to provoke collisions.
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7),
           $urandom_range(0, WAYS - 1), 0);

    // Reset with a lookup response pending: the pulse is dropped.
    tick(1, 2, 0, 0, 0, 0);
    tick(1, 3, 0, 0, 0, 0);
    do_reset();
    idle(NUM_SETS);

    // Flush in RUN after updates; lookup in the flush cycle still answers,
    // updates during the sweep are ignored, a second flush restarts it.
    for (int s = 0; s < 16; s++) update(s, $urandom_range(0, WAYS - 1));
    tick(1, 3, 1, 4, 1, 1);
    for (int i = 0; i < 50; i++)
      tick(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 7), 0);
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NUM_SETS; i++)
      tick(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 7), 0);
    for (int s = 0; s < 16; s++) lookup(s);

    // Reset at sweep count 100; sweep restarts at address 0 in full.
    update(7, 3);
    tick(0, 0, 0, 0, 0, 1);
    idle(100);
    do_reset();
    idle(NUM_SETS);
    lookup(7);
    tick(1, 7, 1, 7, 3, 0);
    lookup(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_lru_ctrl.md
# dcache_lru_ctrl

Sequencer for the data-cache replacement-state RAM: one LOG2_WAYS-bit round-robin victim pointer per set. It zero-fills the RAM after reset or on a flush request, serves victim lookups from the cache pipeline, and writes pointer updates on fills. It sits between the dcache control FSM and the replacement RAM, which the parent instantiates. The RAM has a 1-cycle registered read and resolves same-cycle read/write to the same address by returning the written data.

## Interface
- LOG2_WAYS, 3, pointer width; WAYS = 2**LOG2_WAYS
- INDEX_BITS, 8, set-index width; NUM_SETS = 2**INDEX_BITS
- clock  in  1  sole clock, rising edge
- aclr_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  1-cycle pulse: re-run init sweep
- busy  out  1  init sweep in progress
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready
- lk_index  in  INDEX_BITS  set to look up
- rsp_valid  out  1  victim response valid
- rsp_victim  out  LOG2_WAYS  victim way for the accepted lookup
- upd_valid  in  1  fill completed; always accepted, no ready
- upd_index  in  INDEX_BITS  set filled
- upd_way  in  LOG2_WAYS  way filled
- ram_rden, ram_rdaddress, ram_wren, ram_wraddress, ram_data  out  1/INDEX_BITS/1/INDEX_BITS/LOG2_WAYS  to replacement RAM
- ram_q  in  LOG2_WAYS  RAM read data, valid the cycle after ram_rden

## Operation
- States: INIT, RUN.
- On reset, enter INIT with sweep counter = 0.
- INIT: each cycle ram_wren=1, ram_wraddress=counter, ram_data=0; counter increments. After writing NUM_SETS-1, go to RUN. NUM_SETS cycles total.
- INIT: busy=1, lk_ready=0; upd_valid is ignored, because the sweep overwrites the entry anyway.
- flush in RUN: enter INIT with counter=0 next cycle. A lookup accepted in the flush cycle still returns its response.
- flush in INIT: restart the counter at 0.
- RUN: lk_ready=1. An accepted lookup drives ram_rden=1, ram_rdaddress=lk_index.
- RUN, response: next cycle rsp_valid=1, rsp_victim=ram_q. The victim is held in a register, stable until the next response; rsp_valid is a 1-cycle pulse.
- RUN, update: upd_valid drives ram_wren=1, ram_wraddress=upd_index, ram_data=upd_way+1, wrapping mod WAYS (WAYS-1 → 0).
- Lookup and update in the same cycle are both issued, using the RAM's separate ports.
- A lookup issued in the same cycle as an update to the same index returns the updated pointer, via RAM forwarding.
- A lookup issued one cycle before an update returns the pre-update value.
- ram_rden=0 whenever no lookup is accepted.

## Timing
- Reset values: busy=1, lk_ready=0, rsp_valid=0, rsp_victim=0, ram_wren=0, ram_rden=0, addresses 0, ram_data=0.
- First sweep write occurs in the first cycle after aclr_n deasserts.
- RUN is reached NUM_SETS cycles after reset release; lk_ready rises in that cycle.
- Lookup latency is exactly 1 cycle (accept at t → rsp_valid at t+1). Throughput is 1 lookup per cycle.
- Update is visible to a lookup accepted in the same cycle or any later cycle.
- Reset mid-sweep or mid-lookup: any pending rsp_valid is dropped, and the sweep restarts from 0.

## Structure
- Package dcache_pkg holds:
  - LOG2_WAYS and INDEX_BITS defaults
  - enum lru_state_e {INIT, RUN}
  - function lru_next(way): (way+1) mod WAYS
- No sub-module. The sweep counter, FSM and response register are local to this block.
- The replacement RAM is instantiated by the parent, not here.

## Test plan
- Reset release, no traffic: 256 consecutive writes, addresses 0..255, data 0. busy falls and lk_ready rises in cycle 256. Any lookup then returns victim 0.
- Update index 5 way 2, then lookup index 5 one cycle later: rsp_victim=3. Update way 7 (LOG2_WAYS=3): next lookup returns 0 (wrap).
- Same-cycle update index 9 way 4 and lookup index 9: response next cycle is 5. Lookup index 9 one cycle before that update: response is the prior value.
- Back-to-back lookups to indices 1, 2, 3 after distinct updates: three consecutive rsp_valid pulses, victims match in order.
- flush during RUN after updates: busy high for 256 cycles, lk_ready low, upd_valid ignored. Afterwards all previously updated sets return 0.
- aclr_n asserted at sweep count 100: all outputs return to reset values at once. On release, the sweep restarts at address 0 and takes a full 256 cycles.
